// File: rtl/riscv_mem_bist_init.sv
// Memory BIST initialiser: fills words with pattern^index, optionally reads back.
// Define RISCV_MEM_BIST_READBACK_EN to enable readback compare (READ/DRAIN).
module riscv_mem_bist_init #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [31:0]           base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
  output logic                  MEM_EN_o,
  output logic [31:0]           MEM_ADDR_o,
  output logic [DATA_WIDTH-1:0] MEM_WDATA_o,
  output logic                  MEM_WE_o,
  output logic [3:0]            MEM_BE_o,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA_i,
  input  logic                  MEM_READY_i,
  input  logic                  MEM_ERROR_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [31:0]           fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o
);

`ifdef RISCV_MEM_BIST_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_WRITE, S_DONE
  } state_t;
`endif

  state_t r_state;
  state_t w_next;

  logic [31:0]           r_base;
  logic [31:0]           r_addr;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [DATA_WIDTH-1:0] r_pat;
  logic                  r_done;
  logic                  r_fail;
  logic [31:0]           r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_data;

  logic                  w_acc;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_fail_evt;
  logic [31:0]           w_fail_addr;
  logic [DATA_WIDTH-1:0] w_fail_data;
  logic                  w_unused;

  assign w_acc  = MEM_EN_o & MEM_READY_i;
  assign w_last = (r_idx == (r_num - CNT_WIDTH'(1)));
  assign w_data = r_pat ^ DATA_WIDTH'(r_idx);

  assign MEM_ADDR_o  = r_addr;
  assign MEM_WDATA_o = w_data;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign fail_o      = r_fail;
  assign fail_addr_o = r_fail_addr;
  assign fail_data_o = r_fail_data;

`ifdef RISCV_MEM_BIST_READBACK_EN
  logic                  r_cmp_vld;
  logic                  r_cmp_err;
  logic [31:0]           r_cmp_addr;
  logic [DATA_WIDTH-1:0] r_cmp_exp;

  // Pipeline each accepted read so its data is checked one cycle later
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmp_vld  <= 1'b0;
      r_cmp_err  <= 1'b0;
      r_cmp_addr <= '0;
      r_cmp_exp  <= '0;
    end else begin
      r_cmp_vld  <= (r_state == S_READ) && w_acc;
      r_cmp_err  <= MEM_ERROR_i;
      r_cmp_addr <= r_addr;
      r_cmp_exp  <= w_data;
    end
  end

  assign w_unused = ^base_addr_i[1:0];
`else
  assign w_unused = ^{base_addr_i[1:0], MEM_RDATA_i};
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and memory request decode
  always_comb begin
    w_next   = r_state;
    MEM_EN_o = 1'b0;
    MEM_WE_o = 1'b0;
    MEM_BE_o = 4'h0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i)
          w_next = (num_words_i == '0) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        MEM_EN_o = 1'b1;
        MEM_WE_o = 1'b1;
        MEM_BE_o = 4'hF;
`ifdef RISCV_MEM_BIST_READBACK_EN
        if (w_acc && w_last) w_next = S_READ;
`else
        if (w_acc && w_last) w_next = S_DONE;
`endif
      end
`ifdef RISCV_MEM_BIST_READBACK_EN
      S_READ: begin
        MEM_EN_o = 1'b1;
        MEM_BE_o = 4'hF;
        if (w_acc && w_last) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Failure detection: bus error on a write, or bad/erroring readback
  always_comb begin
    w_fail_evt  = 1'b0;
    w_fail_addr = r_addr;
    w_fail_data = '0;
    if ((r_state == S_WRITE) && w_acc && MEM_ERROR_i)
      w_fail_evt = 1'b1;
`ifdef RISCV_MEM_BIST_READBACK_EN
    if (r_cmp_vld && (r_cmp_err || (MEM_RDATA_i != r_cmp_exp))) begin
      w_fail_evt  = 1'b1;
      w_fail_addr = r_cmp_addr;
      w_fail_data = MEM_RDATA_i;
    end
`endif
  end

  // Run parameters, address walk and sticky first-failure capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base      <= '0;
      r_addr      <= '0;
      r_idx       <= '0;
      r_num       <= '0;
      r_pat       <= '0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_done <= (r_state == S_DONE);
      if ((r_state == S_IDLE) && start_i) begin
        r_base      <= {base_addr_i[31:2], 2'b00};
        r_addr      <= {base_addr_i[31:2], 2'b00};
        r_idx       <= '0;
        r_num       <= num_words_i;
        r_pat       <= pattern_i;
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else begin
        if (w_acc) begin
          if ((r_state == S_WRITE) && w_last) begin
            r_addr <= r_base;
            r_idx  <= '0;
          end else begin
            r_addr <= r_addr + 32'd4;
            r_idx  <= r_idx + CNT_WIDTH'(1);
          end
        end
        if (w_fail_evt && !r_fail) begin
          r_fail      <= 1'b1;
          r_fail_addr <= w_fail_addr;
          r_fail_data <= w_fail_data;
        end
      end
    end
  end

endmodule
